// File: rtl/block_scan_feeder.sv
// block_scan_feeder: buffers 8-row raster strips in a two-bank memory
// and replays each strip as a gapless 8x8 block-ordered pixel stream.
module block_scan_feeder #(
  parameter int DW          = 8,
  parameter int BLK_PER_ROW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_en,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          blk_start,
  output logic          strip_start
);

  localparam int SW  = 8 * BLK_PER_ROW;
  localparam int BSZ = 8 * SW;
  localparam int AW  = $clog2(2 * BSZ);
  localparam int CW  = $clog2(SW);
  localparam int BW  = (BLK_PER_ROW > 1) ?
                       $clog2(BLK_PER_ROW) : 1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DW-1:0] mem [2*BSZ];

  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [CW-1:0] wcol;
  logic [2:0]    wrow;
  logic [BW-1:0] blk;
  logic [2:0]    r;
  logic [2:0]    c;

  logic          wr_fire;
  logic          wr_last;
  logic          issue;
  logic          rd_last;
  logic          rd_end;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;

  assign in_ready = ~full[wr_bank];
  assign wr_fire  = in_valid & in_ready;
  assign wr_last  = wr_fire & (wrow == 3'd7) &
                    (wcol == CW'(SW - 1));

  assign rd_last = (blk == BW'(BLK_PER_ROW - 1)) &
                   (r == 3'd7) & (c == 3'd7);
  assign rd_end  = issue & rd_last;

  assign waddr = AW'(wr_bank) * AW'(BSZ) +
                 AW'(wrow) * AW'(SW) +
                 AW'(wcol);

  assign raddr = AW'(rd_bank) * AW'(BSZ) +
                 AW'(r) * AW'(SW) +
                 AW'(blk) * AW'(8) +
                 AW'(c);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Chaining into the other bank at the last address keeps the
  // stream gapless across strips.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full[rd_bank] && out_en) begin
          issue   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        issue = 1'b1;
        if (rd_last) begin
          if (full[~rd_bank] && out_en)
            state_d = STREAM;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcol    <= '0;
      wrow    <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      if (wcol == CW'(SW - 1)) begin
        wcol <= '0;
        wrow <= wrow + 3'd1;
        if (wrow == 3'd7) wr_bank <= ~wr_bank;
      end else begin
        wcol <= wcol + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk     <= '0;
      r       <= '0;
      c       <= '0;
      rd_bank <= 1'b0;
    end else if (issue) begin
      c <= c + 3'd1;
      if (c == 3'd7) begin
        r <= r + 3'd1;
        if (r == 3'd7) begin
          if (rd_last) blk <= '0;
          else         blk <= blk + BW'(1);
        end
      end
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

  // Set and clear always hit different banks.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
    end else begin
      if (wr_last) full[wr_bank] <= 1'b1;
      if (rd_end)  full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !reset) mem[waddr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      blk_start   <= 1'b0;
      strip_start <= 1'b0;
      pix_data    <= '0;
    end else begin
      pix_valid   <= issue;
      blk_start   <= issue & (r == 3'd0) & (c == 3'd0);
      strip_start <= issue & (blk == '0) &
                     (r == 3'd0) & (c == 3'd0);
      if (issue) pix_data <= mem[raddr];
    end
  end

endmodule
